// File: rtl/bit_scan_pkg.sv
// Shared definitions for the bit-scan unit: op encodings and count-width helper.
package bit_scan_pkg;

  localparam logic [1:0] OP_CLZ = 2'd0;
  localparam logic [1:0] OP_CLO = 2'd1;
  localparam logic [1:0] OP_CTZ = 2'd2;
  localparam logic [1:0] OP_CTO = 2'd3;

  // Count must reach WIDTH itself (all-zero operand), hence the extra bit.
  function automatic int count_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/bit_scan_group.sv
// GROUP-bit priority encoder: all-zero flag plus leading-zero count within the group.
module bit_scan_group
  import bit_scan_pkg::*;
#(
  parameter int GROUP = 4,
  localparam int LW = $clog2(GROUP)
) (
  input  logic [GROUP-1:0] bits,
  output logic             zero,
  output logic [LW-1:0]    cnt
);

  // Scanning upward lets the highest set bit win; an empty group saturates at GROUP-1.
  always_comb begin
    zero = ~|bits;
    cnt  = LW'(GROUP - 1);
    for (int i = 0; i < GROUP; i++) begin
      if (bits[i]) cnt = LW'(GROUP - 1 - i);
    end
  end

endmodule

// File: rtl/bit_scan_unit.sv
// Pipelined leading/trailing zero/one counter with valid/ready handshake, tag and flush.
module bit_scan_unit
  import bit_scan_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [1:0]                      in_op,
  input  logic [WIDTH-1:0]                in_data,
  input  logic [TAG_W-1:0]                in_tag,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [count_width(WIDTH)-1:0]   out_count,
  output logic [TAG_W-1:0]                out_tag
);

  localparam int CW = count_width(WIDTH);
  localparam int NG = WIDTH / GROUP;
  localparam int LW = $clog2(GROUP);

  logic             do_inv, do_rev;
  logic [WIDTH-1:0] rev, norm;

  // Fold all four modes onto a single leading-zero count.
  always_comb begin
    do_inv = (in_op == OP_CLO) || (in_op == OP_CTO);
    do_rev = (in_op == OP_CTZ) || (in_op == OP_CTO);
    for (int i = 0; i < WIDTH; i++) rev[i] = in_data[WIDTH-1-i];
    norm = (do_rev ? rev : in_data) ^ {WIDTH{do_inv}};
  end

  logic [NG-1:0]         zf_c;
  logic [NG-1:0][LW-1:0] gc_c;

  // Group 0 is the most significant slice.
  for (genvar g = 0; g < NG; g++) begin : g_grp
    bit_scan_group #(.GROUP(GROUP)) u_grp (
      .bits (norm[WIDTH-1-g*GROUP -: GROUP]),
      .zero (zf_c[g]),
      .cnt  (gc_c[g])
    );
  end

  logic                  adv_out;
  logic                  src_valid;
  logic [TAG_W-1:0]      src_tag;
  logic [NG-1:0]         zf_s;
  logic [NG-1:0][LW-1:0] gc_s;

  assign adv_out = !out_valid || out_ready;

  if (STAGES == 2) begin : g_s2
    logic                  v1;
    logic [NG-1:0]         zf_r;
    logic [NG-1:0][LW-1:0] gc_r;
    logic [TAG_W-1:0]      tag_r;

    assign in_ready = !v1 || adv_out;

    always_ff @(posedge clk) begin
      if (rst) begin
        v1    <= 1'b0;
        zf_r  <= '0;
        gc_r  <= '0;
        tag_r <= '0;
      end else begin
        if (flush)         v1 <= 1'b0;
        else if (in_ready) v1 <= in_valid;
        if (in_valid && in_ready) begin
          zf_r  <= zf_c;
          gc_r  <= gc_c;
          tag_r <= in_tag;
        end
      end
    end

    assign src_valid = v1;
    assign src_tag   = tag_r;
    assign zf_s      = zf_r;
    assign gc_s      = gc_r;
  end else begin : g_s1
    assign in_ready  = adv_out;
    assign src_valid = in_valid;
    assign src_tag   = in_tag;
    assign zf_s      = zf_c;
    assign gc_s      = gc_c;
  end

  logic [CW-1:0] count_c;

  // Priority mux: the lowest-indexed non-empty group (nearest MSB) wins; none -> WIDTH.
  always_comb begin
    count_c = CW'(WIDTH);
    for (int g = NG - 1; g >= 0; g--) begin
      if (!zf_s[g]) count_c = CW'(g * GROUP) + CW'(gc_s[g]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_count <= '0;
      out_tag   <= '0;
    end else begin
      if (flush)        out_valid <= 1'b0;
      else if (adv_out) out_valid <= src_valid;
      if (adv_out && src_valid) begin
        out_count <= count_c;
        out_tag   <= src_tag;
      end
    end
  end

endmodule

// File: tb/tb_bit_scan_unit.sv
// Bench for bit_scan_unit: a 32-bit two-stage instance and a 64-bit single-stage instance.
module tb_bit_scan_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit, GROUP=4, STAGES=2 instance
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [1:0]  a_op;
  logic [31:0] a_data;
  logic [4:0]  a_tag, a_out_tag;
  logic [5:0]  a_out_count;

  // 64-bit, GROUP=8, STAGES=1 instance
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [1:0]  b_op;
  logic [63:0] b_data;
  logic [4:0]  b_tag, b_out_tag;
  logic [6:0]  b_out_count;

  bit_scan_unit #(.WIDTH(32), .GROUP(4), .STAGES(2), .TAG_W(5)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_op(a_op), .in_data(a_data), .in_tag(a_tag), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_count(a_out_count), .out_tag(a_out_tag));

  bit_scan_unit #(.WIDTH(64), .GROUP(8), .STAGES(1), .TAG_W(5)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_op(b_op), .in_data(b_data), .in_tag(b_tag), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_count(b_out_count), .out_tag(b_out_tag));

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  tag;
    logic [6:0]  exp;
  } vec_t;

  typedef struct {
    logic [6:0] cnt;
    logic [4:0] tag;
    int         acc;
    bit         lat;
  } sb_t;

  sb_t qa[$], qb[$];
  int total = 0, bad = 0, cyc = 0;
  logic [6:0] a_exp, b_exp;
  bit a_lat, b_lat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_cnt(input logic [1:0] op, input logic [63:0] d, input int w);
    int n = 0;
    for (int i = 0; i < w; i++) begin
      logic b;
      b = op[1] ? d[i] : d[w-1-i];
      if (b != op[0]) break;
      n++;
    end
    return 7'(n);
  endfunction

  // Scoreboard push on every accepted operand, pop on every consumed result.
  always @(negedge clk) begin
    if (!rst && a_in_valid && a_in_ready && !a_flush)
      qa.push_back('{cnt: a_exp, tag: a_tag, acc: cyc, lat: a_lat});
    if (!rst && b_in_valid && b_in_ready && !b_flush)
      qb.push_back('{cnt: b_exp, tag: b_tag, acc: cyc, lat: b_lat});
  end

  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) chk("a_unexpected_result", 1, 0);
      else begin
        sb_t e;
        e = qa.pop_front();
        chk("a_count", 64'(a_out_count), 64'(e.cnt));
        chk("a_tag", 64'(a_out_tag), 64'(e.tag));
        if (e.lat) chk("a_latency", 64'(cyc - e.acc), 2);
      end
    end
    if (!rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) chk("b_unexpected_result", 1, 0);
      else begin
        sb_t e;
        e = qb.pop_front();
        chk("b_count", 64'(b_out_count), 64'(e.cnt));
        chk("b_tag", 64'(b_out_tag), 64'(e.tag));
        if (e.lat) chk("b_latency", 64'(cyc - e.acc), 1);
      end
    end
  end

  // Present one operand; back-pressure is released if it stalls too long.
  task automatic a_send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] t,
                        input logic [6:0] e);
    int g = 0;
    a_in_valid = 1'b1; a_op = op; a_data = d; a_tag = t; a_exp = e;
    @(negedge clk);
    while (!a_in_ready && g < 20) begin
      @(posedge clk); #1;
      a_out_ready = 1'b1;
      @(negedge clk);
      g++;
    end
    if (!a_in_ready) chk("a_send_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic b_send(input logic [1:0] op, input logic [63:0] d, input logic [4:0] t,
                        input logic [6:0] e);
    int g = 0;
    b_in_valid = 1'b1; b_op = op; b_data = d; b_tag = t; b_exp = e;
    @(negedge clk);
    while (!b_in_ready && g < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      g++;
    end
    if (!b_in_ready) chk("b_send_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int g = 0;
    while ((qa.size() != 0 || qb.size() != 0) && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain_a_left", 64'(qa.size()), 0);
    chk("drain_b_left", 64'(qb.size()), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t tbl[5];
  vec_t bp[4];

  initial begin
    tbl[0] = '{op: 2'd0, data: 32'h0001_0000, tag: 5'd3,  exp: 7'd15};
    tbl[1] = '{op: 2'd0, data: 32'h0000_0000, tag: 5'd17, exp: 7'd32};
    tbl[2] = '{op: 2'd1, data: 32'hFFF0_0000, tag: 5'd31, exp: 7'd12};
    tbl[3] = '{op: 2'd2, data: 32'h0000_0100, tag: 5'd5,  exp: 7'd8};
    tbl[4] = '{op: 2'd3, data: 32'h0000_00FF, tag: 5'd9,  exp: 7'd8};
    bp[0]  = '{op: 2'd0, data: 32'h0F00_0000, tag: 5'd1,  exp: 7'd4};
    bp[1]  = '{op: 2'd3, data: 32'h0000_0007, tag: 5'd2,  exp: 7'd3};
    bp[2]  = '{op: 2'd1, data: 32'h8000_0000, tag: 5'd4,  exp: 7'd1};
    bp[3]  = '{op: 2'd2, data: 32'h0000_0000, tag: 5'd6,  exp: 7'd32};

    rst = 1'b1;
    a_flush = 0; a_in_valid = 0; a_out_ready = 1; a_op = 0; a_data = 0; a_tag = 0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 1; b_op = 0; b_data = 0; b_tag = 0;
    a_exp = 0; b_exp = 0; a_lat = 0; b_lat = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_a_out_valid", 64'(a_out_valid), 0);
    chk("rst_a_out_count", 64'(a_out_count), 0);
    chk("rst_a_out_tag", 64'(a_out_tag), 0);
    chk("rst_a_in_ready", 64'(a_in_ready), 1);
    chk("rst_b_out_valid", 64'(b_out_valid), 0);
    chk("rst_b_in_ready", 64'(b_in_ready), 1);
    @(posedge clk); #1;

    // Back-to-back table vectors, one per cycle, latency 2
    a_lat = 1;
    for (int i = 0; i < 5; i++) a_send(tbl[i].op, tbl[i].data, tbl[i].tag, tbl[i].exp);
    a_in_valid = 0;
    drain();

    // Back-pressure: five stalled cycles with continuous feed
    a_lat = 0;
    a_out_ready = 0;
    begin
      int j = 0;
      for (int c = 0; c < 5; c++) begin
        a_in_valid = 1; a_op = bp[j].op; a_data = bp[j].data; a_tag = bp[j].tag; a_exp = bp[j].exp;
        @(negedge clk);
        chk("bp_in_ready", 64'(a_in_ready), (c < 2) ? 1 : 0);
        if (c >= 2) begin
          chk("bp_hold_valid", 64'(a_out_valid), 1);
          chk("bp_hold_count", 64'(a_out_count), 4);
          chk("bp_hold_tag", 64'(a_out_tag), 1);
        end
        if (a_in_ready) j++;
        @(posedge clk); #1;
      end
      a_out_ready = 1;
      while (j < 4) begin
        a_send(bp[j].op, bp[j].data, bp[j].tag, bp[j].exp);
        j++;
      end
    end
    a_in_valid = 0;
    drain();

    // Flush with a third operand presented in the flush cycle
    a_lat = 1;
    a_send(2'd0, 32'h0000_0F00, 5'd20, 7'd20);
    a_send(2'd1, 32'hFF00_0000, 5'd21, 7'd8);
    a_flush = 1; a_in_valid = 1; a_op = 2'd0; a_data = 32'h1; a_tag = 5'd22; a_exp = 7'd31;
    @(negedge clk);
    chk("flush_in_ready", 64'(a_in_ready), 1);
    @(posedge clk); #1;
    a_flush = 0; a_in_valid = 0;
    qa.delete();
    @(negedge clk);
    chk("flush_out_valid", 64'(a_out_valid), 0);
    @(posedge clk); #1;
    a_send(2'd3, 32'h0000_000F, 5'd12, 7'd4);
    a_in_valid = 0;
    drain();

    // Mid-stream reset with the pipe full
    a_lat = 0;
    a_out_ready = 0;
    a_send(2'd0, 32'h00FF_0000, 5'd25, 7'd8);
    a_send(2'd2, 32'h0000_0010, 5'd26, 7'd4);
    a_in_valid = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    qa.delete();
    @(negedge clk);
    chk("mrst_out_valid", 64'(a_out_valid), 0);
    chk("mrst_out_count", 64'(a_out_count), 0);
    chk("mrst_out_tag", 64'(a_out_tag), 0);
    chk("mrst_in_ready", 64'(a_in_ready), 1);
    @(posedge clk); #1;
    a_out_ready = 1;

    // Random operands with random back-pressure on the 32-bit instance
    for (int i = 0; i < 40; i++) begin
      logic [31:0] d;
      logic [1:0]  op;
      d  = $urandom();
      d  = ($urandom_range(0, 1) != 0) ? (d >> $urandom_range(0, 32)) : (d << $urandom_range(0, 32));
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) d = ~d;
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_send(op, d, 5'($urandom_range(0, 31)), ref_cnt(op, 64'(d), 32));
    end
    a_in_valid = 0;
    a_out_ready = 1;
    drain();

    // 64-bit single-stage instance: corners then random
    b_lat = 1;
    b_send(2'd0, 64'h0, 5'd7, 7'd64);
    b_send(2'd2, 64'h8000_0000_0000_0000, 5'd8, 7'd63);
    b_send(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 7'd64);
    for (int i = 0; i < 40; i++) begin
      logic [63:0] d;
      logic [1:0]  op;
      d  = {$urandom(), $urandom()};
      d  = ($urandom_range(0, 1) != 0) ? (d >> $urandom_range(0, 64)) : (d << $urandom_range(0, 64));
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) d = ~d;
      b_send(op, d, 5'($urandom_range(0, 31)), ref_cnt(op, d, 64));
    end
    b_in_valid = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
